store_axi_bridge: RTL

Downstream of the memory stage in the pipelined core. Captures one store request per transaction, lane-aligns data and byte strobes, and drives a full AXI4 single-beat write (AW, W, B) to the SoC master port. Holds the pipeline via `req_ready` until the B response returns. Reports misaligned stores and non-OKAY responses.

---
 rtl/store_axi_bridge_pkg.sv | 21 ++
 rtl/store_lane_align.sv | 39 +++
 rtl/store_axi_bridge.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/store_axi_bridge_pkg.sv
// Shared types and constants for the store-to-AXI4 write bridge.
package store_axi_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT_B = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;

    // Request size encodings (bytes) and the matching AXI beat-size codes.
    localparam logic [2:0] SIZE_B    = 3'd1;
    localparam logic [2:0] SIZE_H    = 3'd2;
    localparam logic [2:0] SIZE_W    = 3'd4;
    localparam logic [2:0] AXSIZE_1B = 3'd0;
    localparam logic [2:0] AXSIZE_2B = 3'd1;
    localparam logic [2:0] AXSIZE_4B = 3'd2;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane alignment: places right-justified store data and strobes
// onto the 32-bit bus lanes selected by the low address bits.
module store_lane_align
    import store_axi_bridge_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [2:0]  awsize_o,
    output logic        misaligned_o
);

    logic [3:0] mask;

    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mask         = 4'b1111;
        awsize_o     = AXSIZE_4B;
        misaligned_o = |off_i;
        case (size_i)
            SIZE_B: begin
                mask         = 4'b0001;
                awsize_o     = AXSIZE_1B;
                misaligned_o = 1'b0;
            end
            SIZE_H: begin
                mask         = 4'b0011;
                awsize_o     = AXSIZE_2B;
                misaligned_o = off_i[0];
            end
            default: ;  // illegal sizes behave as a full word
        endcase
        wdata_o = data_i << {off_i, 3'b000};
        wstrb_o = mask << off_i;
    end

endmodule

// File: rtl/store_axi_bridge.sv
// Single-store AXI4 write bridge: accepts one store, issues AW/W as one beat,
// waits for B, and flags misaligned stores or bad responses.
module store_axi_bridge
    import store_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [2:0]  req_size,

    output logic        io_master_awvalid,
    input  logic        io_master_awready,
    output logic [31:0] io_master_awaddr,
    output logic [3:0]  io_master_awid,
    output logic [7:0]  io_master_awlen,
    output logic [2:0]  io_master_awsize,
    output logic [1:0]  io_master_awburst,

    output logic        io_master_wvalid,
    input  logic        io_master_wready,
    output logic [31:0] io_master_wdata,
    output logic [3:0]  io_master_wstrb,
    output logic        io_master_wlast,

    input  logic        io_master_bvalid,
    output logic        io_master_bready,
    input  logic [1:0]  io_master_bresp,
    input  logic [3:0]  io_master_bid,

    output logic        bridge_o_err,
    output logic [31:0] bridge_o_err_addr
);

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  strb_q;
    logic [2:0]  size_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic        err_q;
    logic [31:0] err_addr_q;

    logic [31:0] align_wdata;
    logic [3:0]  align_wstrb;
    logic [2:0]  align_awsize;
    logic        align_misaligned;

    store_lane_align u_align (
        .off_i        (req_addr[1:0]),
        .size_i       (req_size),
        .data_i       (req_data),
        .wdata_o      (align_wdata),
        .wstrb_o      (align_wstrb),
        .awsize_o     (align_awsize),
        .misaligned_o (align_misaligned)
    );

    logic aw_fire;
    logic w_fire;
    logic aw_done_d;
    logic w_done_d;
    logic bad_resp;

    assign aw_fire   = awvalid_q & io_master_awready;
    assign w_fire    = wvalid_q & io_master_wready;
    assign aw_done_d = aw_done_q | aw_fire;
    assign w_done_d  = w_done_q | w_fire;
    assign bad_resp  = (io_master_bresp != RESP_OKAY) || (io_master_bid != AXI_ID);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            size_q     <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (align_misaligned) begin
                            err_q      <= 1'b1;
                            err_addr_q <= req_addr;
                        end else begin
                            addr_q    <= req_addr;
                            data_q    <= align_wdata;
                            strb_q    <= align_wstrb;
                            size_q    <= align_awsize;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (aw_fire) awvalid_q <= 1'b0;
                    if (w_fire)  wvalid_q  <= 1'b0;
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    // Move on in the same cycle the second handshake lands.
                    if (aw_done_d && w_done_d) begin
                        state_q  <= ST_WAIT_B;
                        bready_q <= 1'b1;
                    end
                end
                ST_WAIT_B: begin
                    if (io_master_bvalid) begin
                        state_q   <= ST_IDLE;
                        bready_q  <= 1'b0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        if (bad_resp) begin
                            err_q      <= 1'b1;
                            err_addr_q <= addr_q;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready         = (state_q == ST_IDLE);
    assign io_master_awvalid = awvalid_q;
    assign io_master_awaddr  = addr_q;
    assign io_master_awid    = AXI_ID;
    assign io_master_awlen   = 8'd0;
    assign io_master_awsize  = size_q;
    assign io_master_awburst = BURST_INCR;
    assign io_master_wvalid  = wvalid_q;
    assign io_master_wdata   = data_q;
    assign io_master_wstrb   = strb_q;
    assign io_master_wlast   = 1'b1;
    assign io_master_bready  = bready_q;
    assign bridge_o_err      = err_q;
    assign bridge_o_err_addr = err_addr_q;

endmodule
